// File: rtl/gray_to_bcd_decoder.sv
// gray_to_bcd_decoder
//   Decodes a 4-bit Gray code to binary one bit per cycle (MSB first) and
//   flags results that are not a BCD digit (10-15). A ready/valid handshake
//   is used on both sides, with a saturating count of the erroneous results
//   that were delivered.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   reset        asynchronous active-high reset
//   in_valid     gray_in holds a code to decode
//   gray_in[3:0] Gray code, bit 3 = MSB
//   in_ready     decoder can accept a code (state IDLE)
//   out_valid    bcd_out/error hold a result (state HOLD)
//   bcd_out[3:0] decoded binary value
//   error        decoded value is above 9
//   out_ready    consumer takes the result
//   error_count  saturating count of erroneous results handed over
module gray_to_bcd_decoder #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [3:0]           gray_in,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [3:0]           bcd_out,
  output logic                 error,
  input  logic                 out_ready,
  output logic [ERR_CNT_W-1:0] error_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [3:0]           r_shift;     // latched code, shifted left so bit 3 is g[i]
  logic [3:0]           r_acc;       // binary bits computed so far, newest in bit 0
  logic [1:0]           r_idx;       // index i of the bit computed this cycle
  logic [3:0]           r_bcd;
  logic                 r_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  logic                 w_accept;
  logic                 w_bit;
  logic                 w_last;
  logic                 w_release;
  logic [3:0]           w_result;

  assign w_accept  = (r_state == IDLE) && in_valid;
  // b[i] = g[i] ^ b[i+1]; b[i+1] is the last bit shifted into the
  // accumulator, which is 0 for the first bit because it was cleared.
  assign w_bit     = r_shift[3] ^ r_acc[0];
  assign w_result  = {r_acc[2:0], w_bit};
  assign w_last    = (r_state == SHIFT) && (r_idx == 2'd0);
  assign w_release = (r_state == HOLD) && out_ready;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_next = SHIFT;
      SHIFT:   if (r_idx == 2'd0) w_state_next = HOLD;
      HOLD:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: shift register, accumulator, bit index and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift <= 4'd0;
      r_acc   <= 4'd0;
      r_idx   <= 2'd0;
      r_bcd   <= 4'd0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_shift <= gray_in;
        r_acc   <= 4'd0;
        r_idx   <= 2'd3;
      end else if (r_state == SHIFT) begin
        r_shift <= {r_shift[2:0], 1'b0};
        r_acc   <= w_result;
        r_idx   <= r_idx - 2'd1;
      end
      // Results only change on the SHIFT->HOLD transition.
      if (w_last) begin
        r_bcd <= w_result;
        r_err <= (w_result > 4'd9);
      end
    end
  end

  // Error counter: counts handed-over erroneous results, sticks at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_cnt <= '0;
    end else if (w_release && r_err && !(&r_err_cnt)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == HOLD);
  assign bcd_out     = r_bcd;
  assign error       = r_err;
  assign error_count = r_err_cnt;

endmodule
